instr_decode_unit: RTL and testbench

Multi-cycle instruction decoder with a start/ready handshake. Captures an instruction word, classifies the opcode byte, extracts register and immediate fields, and fetches a second word for extended-length opcodes. Sits between the fetch stage and the execute/control path. Generalises the single-cycle opcode decoder with:
- parametrised byte and word width
- variable instruction length
- illegal-opcode reporting
- a defined output-valid handshake

---
 rtl/decode_pkg.sv | 72 +++++++
 rtl/instr_decode_unit_if.sv | 30 +++
 rtl/opcode_classifier.sv | 35 +++
 rtl/instr_decode_unit.sv | 148 ++++++++++++++
 tb/tb_instr_decode_unit.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/decode_pkg.sv
// Shared types, class boundaries and field helpers for the instruction decoder.
package decode_pkg;

    typedef enum logic [2:0] {
        CLS_NOP     = 3'd0,
        CLS_ALU_RR  = 3'd1,
        CLS_ALU_IMM = 3'd2,
        CLS_MEM     = 3'd3,
        CLS_BRANCH  = 3'd4,
        CLS_EXT     = 3'd5
    } op_class_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_WAIT_EXT,
        ST_DONE
    } state_e;

    // Opcode bits are addressed as distance from the MSB so any BYTE >= 5 works.
    localparam int EXT_BIT_OFS = 1;   // op[BYTE-1] set -> extended opcode
    localparam int ILL_BIT_OFS = 2;   // op[BYTE-2] set -> undefined opcode
    localparam int GRP_OFS     = 3;   // op[BYTE-3 -: 2] selects the group

    localparam logic [1:0] GRP_RR     = 2'b00;
    localparam logic [1:0] GRP_IMM    = 2'b01;
    localparam logic [1:0] GRP_MEM    = 2'b10;
    localparam logic [1:0] GRP_BRANCH = 2'b11;

    // Helpers work on a wide container; callers size-cast the results.
    localparam int FIELD_MAX_W = 128;
    typedef logic [FIELD_MAX_W-1:0] field_t;

    typedef struct packed {
        field_t opcode;
        field_t rd;
        field_t rs1;
        field_t rs2;
        field_t imm;
    } fields_t;

    function automatic field_t get_field(input field_t word, input int unsigned lsb,
                                         input int unsigned width);
        field_t mask;
        mask = (field_t'(1) << width) - field_t'(1);
        return (word >> lsb) & mask;
    endfunction

    function automatic field_t sext(input field_t value, input int unsigned width);
        field_t mask;
        mask = (field_t'(1) << width) - field_t'(1);
        if (value[width-1])
            return value | ~mask;
        else
            return value & mask;
    endfunction

    // Splits word0 into opcode, rd, rs1, rs2 (MSB downwards) and the
    // sign-extended short immediate from the low bits.
    function automatic fields_t extract_fields(input field_t word, input int unsigned word_w,
                                               input int unsigned byte_w, input int unsigned reg_w,
                                               input int unsigned imm_w);
        fields_t f;
        f.opcode = get_field(word, word_w - byte_w, byte_w);
        f.rd     = get_field(word, word_w - byte_w - reg_w, reg_w);
        f.rs1    = get_field(word, word_w - byte_w - 2*reg_w, reg_w);
        f.rs2    = get_field(word, word_w - byte_w - 3*reg_w, reg_w);
        f.imm    = sext(get_field(word, 0, imm_w), imm_w);
        return f;
    endfunction

endpackage

// File: rtl/instr_decode_unit_if.sv
// Fetch-side handshake and decoded-field bus of the instruction decoder.
interface instr_decode_unit_if #(
    parameter int BYTE       = 8,
    parameter int WORD_BYTES = 4,
    parameter int REG_W      = 4
);
    localparam int W = WORD_BYTES * BYTE;

    logic             start;
    logic [W-1:0]     instruction_in;
    logic             ready;
    logic             out_valid;
    logic             illegal;
    logic [2:0]       op_class;
    logic [BYTE-1:0]  opcode;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [W-1:0]     imm;

    modport master (
        output start, instruction_in,
        input  ready, out_valid, illegal, op_class, opcode, rd, rs1, rs2, imm
    );

    modport slave (
        input  start, instruction_in,
        output ready, out_valid, illegal, op_class, opcode, rd, rs1, rs2, imm
    );
endinterface

// File: rtl/opcode_classifier.sv
// Combinational opcode-byte classifier, shared with later pipeline stages.
module opcode_classifier
    import decode_pkg::*;
#(
    parameter int BYTE = 8
) (
    input  logic [BYTE-1:0] op_i,
    output op_class_e       op_class_o,
    output logic            illegal_o,
    output logic            is_ext_o
);
    logic [1:0] grp;
    assign grp = op_i[BYTE-GRP_OFS -: 2];

    // Priority: extended bit, then undefined range, then the group select.
    always_comb begin
        op_class_o = CLS_NOP;
        illegal_o  = 1'b0;
        is_ext_o   = 1'b0;
        if (op_i[BYTE-EXT_BIT_OFS]) begin
            op_class_o = CLS_EXT;
            is_ext_o   = 1'b1;
        end else if (op_i[BYTE-ILL_BIT_OFS]) begin
            illegal_o = 1'b1;
        end else begin
            case (grp)
                GRP_RR:     op_class_o = (op_i == '0) ? CLS_NOP : CLS_ALU_RR;
                GRP_IMM:    op_class_o = CLS_ALU_IMM;
                GRP_MEM:    op_class_o = CLS_MEM;
                GRP_BRANCH: op_class_o = CLS_BRANCH;
                default:    op_class_o = CLS_NOP;
            endcase
        end
    end
endmodule

// File: rtl/instr_decode_unit.sv
// Multi-cycle instruction decoder: captures word0, classifies it, optionally
// fetches word1 for extended opcodes, and presents held decoded fields.
//
// state       | meaning
// ST_IDLE     | waiting for word0, ready=1
// ST_DECODE   | classifying captured word0, ready=0
// ST_WAIT_EXT | extended opcode, waiting for word1, ready=1
// ST_DONE     | out_valid pulse; ready=1 for back-to-back word0
module instr_decode_unit
    import decode_pkg::*;
#(
    parameter int BYTE       = 8,
    parameter int WORD_BYTES = 4,
    parameter int REG_W      = 4,
    parameter int IMM_W      = 16
) (
    input logic                clk,
    input logic                rst_n,
    instr_decode_unit_if.slave bus
);
    localparam int W = WORD_BYTES * BYTE;

    state_e           state_q, state_d;
    logic [W-1:0]     word0_q, word0_d;
    op_class_e        op_class_q, op_class_d;
    logic             illegal_q, illegal_d;
    logic [BYTE-1:0]  opcode_q, opcode_d;
    logic [REG_W-1:0] rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [W-1:0]     imm_q, imm_d;

    op_class_e cls;
    logic      cls_illegal;
    logic      cls_ext;
    fields_t   f;
    logic      load;

    opcode_classifier #(.BYTE(BYTE)) u_classifier (
        .op_i       (word0_q[W-1 -: BYTE]),
        .op_class_o (cls),
        .illegal_o  (cls_illegal),
        .is_ext_o   (cls_ext)
    );

    assign f = extract_fields(field_t'(word0_q), W, BYTE, REG_W, IMM_W);

    // Next-state and field-register update; fields only change on entry to DONE.
    always_comb begin
        state_d    = state_q;
        word0_d    = word0_q;
        op_class_d = op_class_q;
        illegal_d  = illegal_q;
        opcode_d   = opcode_q;
        rd_d       = rd_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        imm_d      = imm_q;
        load       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    word0_d = bus.instruction_in;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (cls_ext) begin
                    state_d = ST_WAIT_EXT;
                end else begin
                    load    = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_WAIT_EXT: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.start) begin
                    word0_d = bus.instruction_in;
                    state_d = ST_DECODE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            opcode_d   = BYTE'(f.opcode);
            op_class_d = cls;
            illegal_d  = cls_illegal;
            rd_d       = REG_W'(f.rd);
            rs1_d      = REG_W'(f.rs1);
            rs2_d      = REG_W'(f.rs2);
            case (cls)
                CLS_ALU_IMM, CLS_MEM, CLS_BRANCH: imm_d = W'(f.imm);
                CLS_EXT:                          imm_d = bus.instruction_in;
                default:                          imm_d = '0;
            endcase
            // Undefined opcodes and NOP report no operands.
            if (cls_illegal || cls == CLS_NOP) begin
                rd_d  = '0;
                rs1_d = '0;
                rs2_d = '0;
                imm_d = '0;
            end
        end
    end

    // State and field registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            word0_q    <= '0;
            op_class_q <= CLS_NOP;
            illegal_q  <= 1'b0;
            opcode_q   <= '0;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            imm_q      <= '0;
        end else begin
            state_q    <= state_d;
            word0_q    <= word0_d;
            op_class_q <= op_class_d;
            illegal_q  <= illegal_d;
            opcode_q   <= opcode_d;
            rd_q       <= rd_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            imm_q      <= imm_d;
        end
    end

    assign bus.ready     = (state_q != ST_DECODE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.illegal   = illegal_q;
    assign bus.op_class  = op_class_q;
    assign bus.opcode    = opcode_q;
    assign bus.rd        = rd_q;
    assign bus.rs1       = rs1_q;
    assign bus.rs2       = rs2_q;
    assign bus.imm       = imm_q;

endmodule

// File: tb/tb_instr_decode_unit.sv
// Self-checking bench for instr_decode_unit at default parameters (32-bit words).
module tb_instr_decode_unit;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    instr_decode_unit_if #(.BYTE(8), .WORD_BYTES(4), .REG_W(4)) bus_if ();

    instr_decode_unit #(.BYTE(8), .WORD_BYTES(4), .REG_W(4), .IMM_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    typedef struct {
        bit          ext;
        logic [31:0] ill;
        logic [31:0] cls;
        logic [31:0] opc;
        logic [31:0] rd;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
    } exp_t;

    // Reference decode from the opcode value ranges and plain arithmetic.
    function automatic exp_t model(input logic [31:0] w0, input logic [31:0] w1);
        exp_t        e;
        int unsigned op;
        int unsigned s;
        op    = w0 / 32'h0100_0000;
        e.ext = 1'b0;
        e.ill = 0;
        e.opc = op;
        e.rd  = (w0 / 32'h0010_0000) % 16;
        e.rs1 = (w0 / 32'h0001_0000) % 16;
        e.rs2 = (w0 / 32'h0000_1000) % 16;
        s     = w0 % 65536;
        e.imm = (s >= 32768) ? s + 32'hFFFF_0000 : s;
        if (op >= 128) begin
            e.ext = 1'b1;
            e.cls = 5;
            e.imm = w1;
        end else if (op >= 64) begin
            e.ill = 1;
            e.cls = 0;
            e.rd  = 0; e.rs1 = 0; e.rs2 = 0; e.imm = 0;
        end else if (op == 0) begin
            e.cls = 0;
            e.rd  = 0; e.rs1 = 0; e.rs2 = 0; e.imm = 0;
        end else if (op < 16) begin
            e.cls = 1;
            e.imm = 0;
        end else begin
            e.cls = 1 + op / 16;
        end
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_fields(input string tag, input exp_t e, input logic ov);
        chk({tag, "_out_valid"}, 32'(bus_if.out_valid), 32'(ov));
        chk({tag, "_illegal"},   32'(bus_if.illegal),   e.ill);
        chk({tag, "_op_class"},  32'(bus_if.op_class),  e.cls);
        chk({tag, "_opcode"},    32'(bus_if.opcode),    e.opc);
        chk({tag, "_rd"},        32'(bus_if.rd),        e.rd);
        chk({tag, "_rs1"},       32'(bus_if.rs1),       e.rs1);
        chk({tag, "_rs2"},       32'(bus_if.rs2),       e.rs2);
        chk({tag, "_imm"},       bus_if.imm,            e.imm);
    endtask

    // Issues one instruction from a ready state and returns in the DONE cycle.
    task automatic run_instr(input string tag, input logic [31:0] w0, input logic [31:0] w1,
                             input int gap, input bit junk, output exp_t e);
        e = model(w0, w1);
        chk({tag, "_ready_accept"}, 32'(bus_if.ready), 32'd1);
        bus_if.start          = 1'b1;
        bus_if.instruction_in = w0;
        step();
        bus_if.start          = junk;
        bus_if.instruction_in = ~w0;
        chk({tag, "_decode_ready"}, 32'(bus_if.ready), 32'd0);
        chk({tag, "_decode_ov"},    32'(bus_if.out_valid), 32'd0);
        step();
        bus_if.start = 1'b0;
        if (e.ext) begin
            for (int i = 0; i < gap; i++) begin
                chk({tag, "_wait_ov"},    32'(bus_if.out_valid), 32'd0);
                chk({tag, "_wait_ready"}, 32'(bus_if.ready), 32'd1);
                step();
            end
            chk({tag, "_wait_ov"},    32'(bus_if.out_valid), 32'd0);
            chk({tag, "_wait_ready"}, 32'(bus_if.ready), 32'd1);
            bus_if.start          = 1'b1;
            bus_if.instruction_in = w1;
            step();
            bus_if.start          = 1'b0;
        end
        chk_fields(tag, e, 1'b1);
        chk({tag, "_done_ready"}, 32'(bus_if.ready), 32'd1);
    endtask

    initial begin
        exp_t        e;
        exp_t        zero;
        logic [31:0] w0;
        logic [31:0] w1;

        zero = '{ext: 1'b0, ill: 0, cls: 0, opc: 0, rd: 0, rs1: 0, rs2: 0, imm: 0};

        // Reset then idle
        rst_n                 = 1'b0;
        bus_if.start          = 1'b0;
        bus_if.instruction_in = '0;
        step();
        step();
        rst_n = 1'b1;
        chk("reset_ready", 32'(bus_if.ready), 32'd1);
        chk_fields("reset", zero, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_ov", 32'(bus_if.out_valid), 32'd0);
        end

        // ALU_IMM with negative immediate, then hold check
        run_instr("alu_imm", 32'h1A3B_FFF0, 32'h0, 0, 1'b0, e);
        chk("alu_imm_cls_const", 32'(bus_if.op_class), 32'd2);
        chk("alu_imm_imm_const", bus_if.imm, 32'hFFFF_FFF0);
        step();
        chk_fields("alu_imm_hold", e, 1'b0);

        // EXT two-word with 3 idle cycles before word1
        run_instr("ext", 32'h8512_0000, 32'hDEAD_BEEF, 3, 1'b0, e);
        chk("ext_imm_const", bus_if.imm, 32'hDEAD_BEEF);
        step();

        // Illegal then back-to-back NOP
        run_instr("illegal", 32'h4000_0000, 32'h0, 0, 1'b0, e);
        chk("illegal_flag_const", 32'(bus_if.illegal), 32'd1);
        run_instr("b2b_nop", 32'h0000_0000, 32'h0, 0, 1'b0, e);
        step();

        // Reset in WAIT_EXT, then ALU_RR
        bus_if.start          = 1'b1;
        bus_if.instruction_in = 32'h8000_0000;
        step();
        bus_if.start = 1'b0;
        step();
        chk("midext_waiting_ov", 32'(bus_if.out_valid), 32'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midext_reset_ready", 32'(bus_if.ready), 32'd1);
        chk_fields("midext_reset", zero, 1'b0);
        run_instr("alu_rr", 32'h0512_3000, 32'h0, 0, 1'b0, e);
        step();

        // start held into DECODE: second word dropped
        run_instr("ign_decode", 32'h2C45_1234, 32'h0, 0, 1'b1, e);
        step();
        chk_fields("ign_decode_idle", e, 1'b0);
        step();
        chk("ign_decode_no_second", 32'(bus_if.out_valid), 32'd0);

        // Randomised instructions against the reference model
        for (int n = 0; n < 60; n++) begin
            w0 = $urandom;
            w1 = $urandom;
            if ($urandom_range(0, 7) == 0) w0 = w0 & 32'h00FF_FFFF;
            run_instr("rand", w0, w1, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), e);
            if ($urandom_range(0, 1) == 1) begin
                step();
                chk_fields("rand_hold", e, 1'b0);
                chk("rand_idle_ready", 32'(bus_if.ready), 32'd1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
